// File: rtl/apb_rb_pkg.sv
// Shared types and helpers for the multi-target APB to register-bus bridge.
package apb_rb_pkg;

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;
  typedef enum logic {OKAY, SLVERR} resp_t;

  localparam int IDX_CALC_W = 64;

  // Full-width shift so out-of-range upper address bits still reach the range check.
  function automatic logic [IDX_CALC_W-1:0] tgt_index(input logic [IDX_CALC_W-1:0] addr,
                                                      input int unsigned shift);
    return addr >> shift;
  endfunction

endpackage

// File: rtl/apb_rb_target_mux.sv
// Selects one target's read data, acks and errors by index, and fans a single
// read/write strobe request out to a one-hot per-target vector.
module apb_rb_target_mux
  import apb_rb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_TARGETS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [IDX_W-1:0]                  sel_idx,
  input  logic [NUM_TARGETS*DATA_WIDTH-1:0] rb_rdata,
  input  logic [NUM_TARGETS-1:0]            rb_wack,
  input  logic [NUM_TARGETS-1:0]            rb_rack,
  input  logic [NUM_TARGETS-1:0]            rb_waddrerr,
  input  logic [NUM_TARGETS-1:0]            rb_raddrerr,
  output logic [DATA_WIDTH-1:0]             sel_rdata,
  output logic                              sel_wack,
  output logic                              sel_rack,
  output logic                              sel_waddrerr,
  output logic                              sel_raddrerr,
  input  logic [IDX_W-1:0]                  fo_idx,
  input  logic                              fo_wr,
  input  logic                              fo_rd,
  output logic [NUM_TARGETS-1:0]            fo_wstrobe,
  output logic [NUM_TARGETS-1:0]            fo_rstrobe
);

  // Compare against each legal index so an out-of-range index never slices past the bus.
  always_comb begin
    sel_rdata    = '0;
    sel_wack     = 1'b0;
    sel_rack     = 1'b0;
    sel_waddrerr = 1'b0;
    sel_raddrerr = 1'b0;
    fo_wstrobe   = '0;
    fo_rstrobe   = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_rdata    = rb_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wack     = rb_wack[i];
        sel_rack     = rb_rack[i];
        sel_waddrerr = rb_waddrerr[i];
        sel_raddrerr = rb_raddrerr[i];
      end
      if (fo_idx == IDX_W'(i)) begin
        fo_wstrobe[i] = fo_wr;
        fo_rstrobe[i] = fo_rd;
      end
    end
  end

endmodule

// File: rtl/apb_regbus_bridge_mc.sv
// APB3/APB4 slave bridging onto several register-bus targets with address
// decode, byte strobes, ack-driven completion, timeout and optional privilege check.
module apb_regbus_bridge_mc
  import apb_rb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_TARGETS = 2,
  parameter int TGT_SHIFT   = 12,
  parameter int TIMEOUT     = 64,
  parameter int PROT_CHECK  = 0
) (
  input  logic                              clk,
  input  logic                              presetn,
  input  logic [ADDR_WIDTH-1:0]             paddr,
  input  logic                              psel,
  input  logic                              penable,
  input  logic                              pwrite,
  input  logic [DATA_WIDTH-1:0]             pwdata,
  input  logic [DATA_WIDTH/8-1:0]           pstrb,
  input  logic [2:0]                        pprot,
  output logic [DATA_WIDTH-1:0]             prdata,
  output logic                              pready,
  output logic                              pslverr,
  output logic [ADDR_WIDTH-1:0]             rb_addr,
  output logic [DATA_WIDTH-1:0]             rb_wdata,
  output logic [DATA_WIDTH/8-1:0]           rb_wstrb,
  output logic [NUM_TARGETS-1:0]            rb_wstrobe,
  output logic [NUM_TARGETS-1:0]            rb_rstrobe,
  input  logic [NUM_TARGETS*DATA_WIDTH-1:0] rb_rdata,
  input  logic [NUM_TARGETS-1:0]            rb_wack,
  input  logic [NUM_TARGETS-1:0]            rb_rack,
  input  logic [NUM_TARGETS-1:0]            rb_waddrerr,
  input  logic [NUM_TARGETS-1:0]            rb_raddrerr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t state, nstate;

  logic                  wr_q, wr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d, rdata_d;
  logic [STRB_W-1:0]     wstrb_d;
  logic [NUM_TARGETS-1:0] wstrobe_d, rstrobe_d;
  logic                  ready_d;
  resp_t                 resp_d;

  logic [IDX_CALC_W-1:0] idx_full;
  logic [IDX_W-1:0]      idx_dec;
  logic                  idx_ok, prot_ok, req_err, req_noop, setup;
  logic                  issue, issue_wr, issue_rd;
  logic                  ack_hit, err_hit, tmo_hit;
  logic                  unused_prot;

  logic [DATA_WIDTH-1:0]  sel_rdata;
  logic                   sel_wack, sel_rack, sel_waddrerr, sel_raddrerr;
  logic [NUM_TARGETS-1:0] fo_wstrobe, fo_rstrobe;

  assign idx_full    = tgt_index(IDX_CALC_W'(paddr), TGT_SHIFT);
  assign idx_dec     = idx_full[IDX_W-1:0];
  assign idx_ok      = idx_full < IDX_CALC_W'(NUM_TARGETS);
  assign prot_ok     = (PROT_CHECK == 0) || pprot[0];
  assign unused_prot = ^pprot[2:1];
  assign setup       = psel && !penable;
  assign req_err     = !idx_ok || !prot_ok;
  assign req_noop    = pwrite && (pstrb == '0);
  assign issue       = (state == IDLE) && setup && !req_err && !req_noop;
  assign issue_wr    = issue && pwrite;
  assign issue_rd    = issue && !pwrite;

  // Only the selected target's ack of the matching direction can complete an access.
  assign ack_hit = wr_q ? (sel_wack || sel_waddrerr) : (sel_rack || sel_raddrerr);
  assign err_hit = wr_q ? sel_waddrerr : sel_raddrerr;
  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  apb_rb_target_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_TARGETS(NUM_TARGETS),
    .IDX_W      (IDX_W)
  ) u_mux (
    .sel_idx     (idx_q),
    .rb_rdata    (rb_rdata),
    .rb_wack     (rb_wack),
    .rb_rack     (rb_rack),
    .rb_waddrerr (rb_waddrerr),
    .rb_raddrerr (rb_raddrerr),
    .sel_rdata   (sel_rdata),
    .sel_wack    (sel_wack),
    .sel_rack    (sel_rack),
    .sel_waddrerr(sel_waddrerr),
    .sel_raddrerr(sel_raddrerr),
    .fo_idx      (idx_dec),
    .fo_wr       (issue_wr),
    .fo_rd       (issue_rd),
    .fo_wstrobe  (fo_wstrobe),
    .fo_rstrobe  (fo_rstrobe)
  );

  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:   if (setup) nstate = (req_err || req_noop) ? RESP : STROBE;
      STROBE,
      WAIT: begin
        if (!psel)                          nstate = IDLE;
        else if (ack_hit)                   nstate = RESP;
        else if (state == WAIT && tmo_hit)  nstate = RESP;
        else                                nstate = WAIT;
      end
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Next values of every registered output; a dropped psel falls through with all zeros.
  always_comb begin
    wr_d      = wr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    addr_d    = rb_addr;
    wdata_d   = rb_wdata;
    wstrb_d   = rb_wstrb;
    wstrobe_d = '0;
    rstrobe_d = '0;
    ready_d   = 1'b0;
    resp_d    = OKAY;
    rdata_d   = '0;
    case (state)
      IDLE: begin
        if (setup) begin
          wr_d      = pwrite;
          idx_d     = idx_dec;
          addr_d    = paddr;
          wdata_d   = pwdata;
          wstrb_d   = pstrb;
          wstrobe_d = fo_wstrobe;
          rstrobe_d = fo_rstrobe;
          if (req_err || req_noop) begin
            ready_d = 1'b1;
            resp_d  = req_err ? SLVERR : OKAY;
          end
        end
      end
      STROBE,
      WAIT: begin
        if (state == STROBE)       cnt_d = '0;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (psel) begin
          if (ack_hit) begin
            ready_d = 1'b1;
            resp_d  = err_hit ? SLVERR : OKAY;
            if (!wr_q && !err_hit) rdata_d = sel_rdata;
          end else if (state == WAIT && tmo_hit) begin
            ready_d = 1'b1;
            resp_d  = SLVERR;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      wr_q       <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      rb_addr    <= '0;
      rb_wdata   <= '0;
      rb_wstrb   <= '0;
      rb_wstrobe <= '0;
      rb_rstrobe <= '0;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      prdata     <= '0;
    end else begin
      wr_q       <= wr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rb_addr    <= addr_d;
      rb_wdata   <= wdata_d;
      rb_wstrb   <= wstrb_d;
      rb_wstrobe <= wstrobe_d;
      rb_rstrobe <= rstrobe_d;
      pready     <= ready_d;
      pslverr    <= (resp_d == SLVERR);
      prdata     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_apb_regbus_bridge_mc.sv
// Bench for apb_regbus_bridge_mc: scripted APB accesses with per-cycle ack
// scheduling; expected responses queue up at setup and are matched on pready.
module tb_apb_regbus_bridge_mc;
  import apb_rb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int NT = 2;
  localparam int TO = 8;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             presetn;
  logic [AW-1:0]    paddr;
  logic             psel, penable, pwrite;
  logic [DW-1:0]    pwdata;
  logic [SW-1:0]    pstrb;
  logic [2:0]       pprot;
  logic [DW-1:0]    prdata;
  logic             pready, pslverr;
  logic [AW-1:0]    rb_addr;
  logic [DW-1:0]    rb_wdata;
  logic [SW-1:0]    rb_wstrb;
  logic [NT-1:0]    rb_wstrobe, rb_rstrobe;
  logic [NT*DW-1:0] rb_rdata;
  logic [NT-1:0]    rb_wack, rb_rack, rb_waddrerr, rb_raddrerr;

  exp_t sb[$];
  int   assert_count = 0;
  int   fail_count   = 0;

  apb_regbus_bridge_mc #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_TARGETS(NT),
    .TGT_SHIFT  (12),
    .TIMEOUT    (TO),
    .PROT_CHECK (1)
  ) dut (
    .clk        (clk),
    .presetn    (presetn),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .pprot      (pprot),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .rb_addr    (rb_addr),
    .rb_wdata   (rb_wdata),
    .rb_wstrb   (rb_wstrb),
    .rb_wstrobe (rb_wstrobe),
    .rb_rstrobe (rb_rstrobe),
    .rb_rdata   (rb_rdata),
    .rb_wack    (rb_wack),
    .rb_rack    (rb_rack),
    .rb_waddrerr(rb_waddrerr),
    .rb_raddrerr(rb_raddrerr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clearAcks();
    rb_wack     = '0;
    rb_rack     = '0;
    rb_waddrerr = '0;
    rb_raddrerr = '0;
  endtask

  // Drives one APB access; ack_cyc/stray_cyc are cycles after setup (-1 = never).
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                               input logic [SW-1:0] strb, input logic [2:0] prot,
                               input int ack_cyc, input logic ack_err, input logic [DW-1:0] ack_data,
                               input int stray_cyc, input int exp_ready, input logic exp_err,
                               input logic [DW-1:0] exp_data, input logic exp_strobe);
    int            tgt;
    logic [NT-1:0] exp_r, exp_w;
    bit            done;
    tgt   = int'(addr >> 12);
    exp_r = '0;
    exp_w = '0;
    if (exp_strobe) begin
      if (wr) exp_w[tgt] = 1'b1;
      else    exp_r[tgt] = 1'b1;
    end
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr;
    pwdata = wdata; pstrb = strb; pprot = prot;
    sb.push_back('{err: exp_err, data: exp_data});
    done = 1'b0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      clearAcks();
      if (k == 1) begin
        checkOutput("rstrobe_t1", rb_rstrobe, exp_r);
        checkOutput("wstrobe_t1", rb_wstrobe, exp_w);
        checkOutput("rb_addr", rb_addr, addr);
        if (wr) begin
          checkOutput("rb_wstrb", rb_wstrb, strb);
          checkOutput("rb_wdata", rb_wdata, wdata);
        end
      end
      if (k == 2) checkOutput("strobe_t2", {rb_rstrobe, rb_wstrobe}, '0);
      if (pready) begin
        checkOutput("ready_cycle", k, exp_ready);
        done = 1'b1;
      end else begin
        penable = 1'b1;
        if (k == ack_cyc) begin
          if (wr) begin
            rb_wack[tgt] = 1'b1;
            if (ack_err) rb_waddrerr[tgt] = 1'b1;
          end else begin
            rb_rack[tgt] = 1'b1;
            if (ack_err) rb_raddrerr[tgt] = 1'b1;
            rb_rdata[tgt*DW +: DW] = ack_data;
          end
        end
        if (k == stray_cyc) begin
          rb_rack[1-tgt] = 1'b1;
          rb_rdata[(1-tgt)*DW +: DW] = 32'hBAD0_BAD0;
          if (!wr) rb_wack[tgt] = 1'b1;
        end
      end
    end
    if (!done) checkOutput("ready_timeout", 0, 1);
    @(negedge clk);
    checkOutput("ready_one_cycle", pready, 0);
    psel = 1'b0; penable = 1'b0;
    clearAcks();
  endtask

  // Scoreboard: every pready must match the oldest outstanding expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (pready === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_pready", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("pslverr", pslverr, e.err);
          checkOutput("prdata", prdata, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b001;
    rb_rdata = {32'h7777_1111, 32'h5555_AAAA};
    clearAcks();
    repeat (2) @(negedge clk);
    checkOutput("rst_pready", pready, 0);
    checkOutput("rst_strobes", {rb_rstrobe, rb_wstrobe}, '0);
    checkOutput("rst_prdata", prdata, 0);
    checkOutput("rst_state", dut.state, IDLE);
    presetn = 1'b1;

    // addr, wr, wdata, strb, prot, ack_cyc, ack_err, ack_data, stray, exp_ready, exp_err, exp_data, strobe
    applyStimulus(16'h1004, 0, 32'h0, 4'hF, 3'b001, 1, 0, 32'hCAFE_0001, -1, 2, 0, 32'hCAFE_0001, 1);
    applyStimulus(16'h0008, 1, 32'h1234_5678, 4'b0101, 3'b001, 4, 0, 32'h0, -1, 5, 0, 32'h0, 1);
    applyStimulus(16'h3000, 0, 32'h0, 4'hF, 3'b001, -1, 0, 32'h0, -1, 1, 1, 32'h0, 0);
    applyStimulus(16'h0020, 0, 32'h0, 4'hF, 3'b001, -1, 0, 32'h0, -1, TO + 2, 1, 32'h0, 1);
    applyStimulus(16'h1100, 0, 32'h0, 4'hF, 3'b001, 4, 0, 32'hCAFE_0004, 2, 5, 0, 32'hCAFE_0004, 1);
    applyStimulus(16'h0040, 0, 32'h0, 4'hF, 3'b000, 1, 0, 32'h1111_2222, -1, 1, 1, 32'h0, 0);
    applyStimulus(16'h1008, 1, 32'hA5A5_A5A5, 4'b0000, 3'b001, 1, 0, 32'h0, -1, 1, 0, 32'h0, 0);
    applyStimulus(16'h000C, 0, 32'h0, 4'hF, 3'b001, 3, 1, 32'hDEAD_BEEF, -1, 4, 1, 32'h0, 1);
    applyStimulus(16'h1010, 1, 32'h0F0F_0F0F, 4'b1000, 3'b001, 1, 1, 32'h0, -1, 2, 1, 32'h0, 1);
    applyStimulus(16'hF000, 1, 32'h0BAD_0BAD, 4'b1111, 3'b001, -1, 0, 32'h0, -1, 1, 1, 32'h0, 0);

    // psel dropped right after the strobe: no response, address stays latched
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = 16'h1040; pwrite = 1'b0; pprot = 3'b001;
    @(negedge clk);
    checkOutput("abort_strobe", rb_rstrobe, 2'b10);
    psel = 1'b0; penable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("abort_no_ready", pready, 0);
    end
    checkOutput("abort_addr_held", rb_addr, 16'h1040);

    // asynchronous reset while the bridge is waiting for an ack
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = 16'h0010; pwrite = 1'b0; pwdata = 32'h9999_0000;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    presetn = 1'b0;
    #1;
    checkOutput("mid_rst_pready", pready, 0);
    checkOutput("mid_rst_pslverr", pslverr, 0);
    checkOutput("mid_rst_prdata", prdata, 0);
    checkOutput("mid_rst_strobes", {rb_rstrobe, rb_wstrobe}, '0);
    checkOutput("mid_rst_addr", rb_addr, 0);
    checkOutput("mid_rst_wdata", rb_wdata, 0);
    checkOutput("mid_rst_wstrb", rb_wstrb, 0);
    checkOutput("mid_rst_state", dut.state, IDLE);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    presetn = 1'b1;
    applyStimulus(16'h0030, 0, 32'h0, 4'hF, 3'b001, 2, 0, 32'h600D_0002, -1, 3, 0, 32'h600D_0002, 1);

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
